// File: rtl/gf_pkg.sv
// Shared definitions for the GF reduction arbiter: FSM states, grade width
// and the table of irreducible field polynomials indexed by field grade.
package gf_pkg;

  localparam int GF_TABLE_MAX = 32;
  localparam int GF_GRADE_W   = $clog2(GF_TABLE_MAX) + 1;
  localparam int GF_POLY_W    = GF_TABLE_MAX + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } gf_state_e;

  // Entry m is the irreducible polynomial of degree m (bit i = coeff of x^i).
  // Grades 0 and 1 have no useful field and read as 0.
  localparam logic [GF_POLY_W-1:0] GF_IRRED_TABLE [0:GF_TABLE_MAX] = '{
    33'd0,          33'd0,          33'd7,          33'd11,
    33'd19,         33'd37,         33'd67,         33'd131,
    33'd285,        33'd529,        33'd1033,       33'd2053,
    33'd4179,       33'd8219,       33'd17475,      33'd32771,
    33'd69643,      33'd131081,     33'd262273,     33'd524327,
    33'd1048585,    33'd2097157,    33'd4194307,    33'd8388641,
    33'd16777351,   33'd33554441,   33'd67108935,   33'd134217767,
    33'd268435465,  33'd536870917,  33'd1082130439, 33'd2147483657,
    33'd4299161607
  };

  // Table lookup that returns 0 for grades beyond the table.
  function automatic logic [GF_POLY_W-1:0] irred_poly(input logic [GF_GRADE_W-1:0] grade);
    logic [GF_POLY_W-1:0] poly;
    poly = '0;
    if (int'(grade) <= GF_TABLE_MAX) poly = GF_IRRED_TABLE[grade];
    return poly;
  endfunction

endpackage

// File: rtl/gf_rr_arb2.sv
// Two-way round-robin grant: on a conflict the requester not served last
// wins; the pointer starts out favouring requester 0.
module gf_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       take,
  output logic       gnt_any,
  output logic       gnt_id
);

  logic prio_q;
  logic prio_d;

  // Pick the winner: priority pointer only matters when both are asking.
  always_comb begin
    gnt_any = |req_valid;
    if (&req_valid) gnt_id = prio_q;
    else            gnt_id = req_valid[1];
  end

  // Once a grant is consumed, hand priority to the other requester.
  always_comb begin
    prio_d = prio_q;
    if (take && gnt_any) prio_d = ~gnt_id;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/gf_red_arbiter.sv
// Arbitrates two requesters onto one external GF reduction unit, validates
// the field grade, supervises the unit with a busy timeout and returns the
// reduced value (or an error) through a valid/ready response port.
module gf_red_arbiter
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_GF     = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req0_valid,
  output logic                             req0_ready,
  input  logic [$clog2(DATA_WIDTH):0]      req0_grade,
  input  logic [2*DATA_WIDTH-1:0]          req0_operand,
  input  logic                             req1_valid,
  output logic                             req1_ready,
  input  logic [$clog2(DATA_WIDTH):0]      req1_grade,
  input  logic [2*DATA_WIDTH-1:0]          req1_operand,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_id,
  output logic                             rsp_err,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             red_op_enable,
  output logic [$clog2(DATA_WIDTH):0]      red_polyn_grade,
  output logic [DATA_WIDTH:0]              red_polyn_red_in,
  output logic [2*DATA_WIDTH-1:0]          red_reduc_in,
  input  logic [DATA_WIDTH-1:0]            red_out,
  input  logic                             red_op_finish
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = DATA_WIDTH + 1;
  localparam logic [GW-1:0] GRADE_MIN = GW'(2);
  localparam logic [GW-1:0] GRADE_MAX = GW'(MAX_GF);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

  gf_state_e               state_q, state_d;
  logic [GW-1:0]           grade_q, grade_d;
  logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
  logic [PW-1:0]           poly_q, poly_d;
  logic                    id_q, id_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    gnt_any;
  logic                    gnt_id;
  logic                    take;
  logic [GW-1:0]           sel_grade;
  logic [2*DATA_WIDTH-1:0] sel_operand;
  logic                    sel_legal;

  gf_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid ({req1_valid, req0_valid}),
    .take      (take),
    .gnt_any   (gnt_any),
    .gnt_id    (gnt_id)
  );

  // Route the granted requester's fields and judge its grade.
  always_comb begin
    sel_grade   = gnt_id ? req1_grade   : req0_grade;
    sel_operand = gnt_id ? req1_operand : req0_operand;
    sel_legal   = (sel_grade >= GRADE_MIN) && (sel_grade <= GRADE_MAX);
  end

  // State and operation registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grade_q   <= '0;
      operand_q <= '0;
      poly_q    <= '0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grade_q   <= grade_d;
      operand_q <= operand_d;
      poly_q    <= poly_d;
      id_q      <= id_d;
      err_q     <= err_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state: accept in IDLE, wait for finish or timeout in BUSY, hold in RESP.
  always_comb begin
    state_d   = state_q;
    grade_d   = grade_q;
    operand_d = operand_q;
    poly_d    = poly_q;
    id_d      = id_q;
    err_d     = err_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          grade_d   = sel_grade;
          operand_d = sel_operand;
          id_d      = gnt_id;
          cnt_d     = '0;
          result_d  = '0;
          if (sel_legal) begin
            poly_d  = PW'(irred_poly(GF_GRADE_W'(sel_grade)));
            err_d   = 1'b0;
            state_d = ST_BUSY;
          end else begin
            poly_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (red_op_finish) begin
          result_d = red_out;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state; ready is masked during reset.
  always_comb begin
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp_valid     = 1'b0;
    red_op_enable = 1'b0;
    take          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        take       = gnt_any;
        req0_ready = rst_n & gnt_any & ~gnt_id;
        req1_ready = rst_n & gnt_any & gnt_id;
      end
      ST_BUSY: red_op_enable = 1'b1;
      ST_RESP: rsp_valid     = 1'b1;
      default: ;
    endcase
  end

  assign rsp_id           = id_q;
  assign rsp_err          = err_q;
  assign rsp_data         = result_q;
  assign red_polyn_grade  = grade_q;
  assign red_polyn_red_in = poly_q;
  assign red_reduc_in     = operand_q;

endmodule
